// File: rtl/execute_if.sv
// ----------------------------------------------------------------------------
// execute_pkg / execute_if
//  Shared types and the ID <-> EX bus for the EX stage of the RV32 pipeline.
//
//  execute_pkg
//    ex_mem_t      EX/MEM pipeline register contents
//    OP_*          alu_op encodings (18-31 are illegal)
//
//  execute_if  (ID side = master, EX stage = slave)
//    id_valid    ID->EX  1   ID/EX holds a real instruction
//    alu_op      ID->EX  5   operation select
//    rs1_data    ID->EX  32  operand A (already forwarded)
//    rs2_data    ID->EX  32  rs2 value / store data
//    imm         ID->EX  32  sign-extended immediate
//    alu_src     ID->EX  1   1 = imm is operand B
//    rd          ID->EX  5   destination register
//    RegWrite    ID->EX  1   write-back enable
//    MemWrite    ID->EX  1   store enable
//    MemToReg    ID->EX  1   load select for write-back
//    flush       ID->EX  1   kill the instruction in EX (and any divide)
//    ex_stall    EX->ID  1   ID must hold its instruction
//    ex_illegal  EX->ID  1   1-cycle pulse, illegal op retired as a bubble
//    ex_mem      EX->MEM     registered EX/MEM contents
// ----------------------------------------------------------------------------
package execute_pkg;

   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] rs2_data;
      logic [4:0]  rd;
      logic        RegWrite;
      logic        MemWrite;
      logic        MemToReg;
   } ex_mem_t;

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_AND   = 5'd2;
   localparam logic [4:0] OP_OR    = 5'd3;
   localparam logic [4:0] OP_XOR   = 5'd4;
   localparam logic [4:0] OP_SLL   = 5'd5;
   localparam logic [4:0] OP_SRL   = 5'd6;
   localparam logic [4:0] OP_SRA   = 5'd7;
   localparam logic [4:0] OP_SLT   = 5'd8;
   localparam logic [4:0] OP_SLTU  = 5'd9;
   localparam logic [4:0] OP_MUL   = 5'd10;
   localparam logic [4:0] OP_MULH  = 5'd11;
   localparam logic [4:0] OP_MULHU = 5'd12;
   localparam logic [4:0] OP_DIV   = 5'd13;
   localparam logic [4:0] OP_DIVU  = 5'd14;
   localparam logic [4:0] OP_REM   = 5'd15;
   localparam logic [4:0] OP_REMU  = 5'd16;
   localparam logic [4:0] OP_PASSB = 5'd17;

endpackage

interface execute_if;
   logic                  id_valid;
   logic [4:0]            alu_op;
   logic [31:0]           rs1_data;
   logic [31:0]           rs2_data;
   logic [31:0]           imm;
   logic                  alu_src;
   logic [4:0]            rd;
   logic                  RegWrite;
   logic                  MemWrite;
   logic                  MemToReg;
   logic                  flush;
   logic                  ex_stall;
   logic                  ex_illegal;
   execute_pkg::ex_mem_t  ex_mem;

   modport master (
      output id_valid, alu_op, rs1_data, rs2_data, imm, alu_src,
             rd, RegWrite, MemWrite, MemToReg, flush,
      input  ex_stall, ex_illegal, ex_mem
   );

   modport slave (
      input  id_valid, alu_op, rs1_data, rs2_data, imm, alu_src,
             rd, RegWrite, MemWrite, MemToReg, flush,
      output ex_stall, ex_illegal, ex_mem
   );
endinterface

// File: rtl/execute.sv
// ----------------------------------------------------------------------------
// execute
//  EX stage of the 5-stage RV32 pipeline. Single-cycle ALU/shift/compare ops
//  are registered into EX/MEM at the next edge. DIV/DIVU/REM/REMU run on an
//  iterative restoring divider with a fixed latency; ID is stalled and bubbles
//  go into EX/MEM while the divide is in flight.
//
//  Optional feature: define EXECUTE_MUL_EN to make ops 10-12 single-cycle
//  32x32 multiplies. Without it those ops are illegal (bubble + ex_illegal).
//
//  Parameters
//    DIV_BITS_PER_CYCLE  quotient bits per cycle (1 or 2)
//
//  Ports
//    clk       rising-edge clock
//    reset_n   asynchronous active-low reset
//    bus       execute_if.slave (ID inputs, ex_stall/ex_illegal/ex_mem out)
// ----------------------------------------------------------------------------
module execute #(
   parameter int DIV_BITS_PER_CYCLE = 1
) (
   input  logic      clk,
   input  logic      reset_n,
   execute_if.slave  bus
);
   import execute_pkg::*;

   localparam int         DIV_CYCLES = 32 / DIV_BITS_PER_CYCLE;
   localparam logic [4:0] CNT_INIT   = 5'(DIV_CYCLES - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      DIV_RUN = 1'b1
   } state_t;

   state_t      state_reg, state_next;
   ex_mem_t     ex_mem_reg, ex_mem_next;
   logic        ex_illegal_reg, ex_illegal_next;
   logic        stall;
   logic        issue;

   // divider state
   logic [31:0] quo_reg;     // dividend shifting out / quotient shifting in
   logic [31:0] rem_reg;     // partial remainder
   logic [31:0] dvs_reg;     // |divisor|
   logic [4:0]  cnt_reg;
   logic        neg_q_reg;
   logic        neg_r_reg;
   logic        is_rem_reg;
   logic [31:0] rs2_hold_reg;
   logic [4:0]  rd_hold_reg;
   logic        rw_hold_reg;
   logic        mw_hold_reg;
   logic        mtr_hold_reg;

   // operand selection and single-cycle ALU
   logic [31:0] op_a, op_b;
   logic [31:0] alu_res;
   logic        op_illegal;
   logic        op_is_div;
   logic        div_signed;
   logic        div_is_rem;

   assign op_a = bus.rs1_data;
   assign op_b = bus.alu_src ? bus.imm : bus.rs2_data;

`ifdef EXECUTE_MUL_EN
   // One unsigned multiplier; the signed high word is recovered by
   // subtracting the sign corrections from the unsigned high word.
   logic [63:0] prod_uu;
   logic [31:0] mulh_ss;
   assign prod_uu = {32'd0, op_a} * {32'd0, op_b};
   assign mulh_ss = prod_uu[63:32]
                    - (op_a[31] ? op_b : 32'd0)
                    - (op_b[31] ? op_a : 32'd0);
`endif

   always_comb begin
      alu_res    = '0;
      op_illegal = 1'b0;
      op_is_div  = 1'b0;
      case (bus.alu_op)
         OP_ADD:   alu_res = op_a + op_b;
         OP_SUB:   alu_res = op_a - op_b;
         OP_AND:   alu_res = op_a & op_b;
         OP_OR:    alu_res = op_a | op_b;
         OP_XOR:   alu_res = op_a ^ op_b;
         OP_SLL:   alu_res = op_a << op_b[4:0];
         OP_SRL:   alu_res = op_a >> op_b[4:0];
         OP_SRA:   alu_res = 32'($signed(op_a) >>> op_b[4:0]);
         OP_SLT:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
         OP_SLTU:  alu_res = {31'd0, op_a < op_b};
`ifdef EXECUTE_MUL_EN
         OP_MUL:   alu_res = prod_uu[31:0];
         OP_MULH:  alu_res = mulh_ss;
         OP_MULHU: alu_res = prod_uu[63:32];
`endif
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: op_is_div = 1'b1;
         OP_PASSB: alu_res = op_b;
         default:  op_illegal = 1'b1;
      endcase
   end

   assign div_signed = (bus.alu_op == OP_DIV) || (bus.alu_op == OP_REM);
   assign div_is_rem = (bus.alu_op == OP_REM) || (bus.alu_op == OP_REMU);

   // Restoring division, DIV_BITS_PER_CYCLE steps per clock. The compare is
   // done on 33 bits; the subtraction fits in 32 because the true remainder
   // is always below the divisor. A zero divisor naturally gives an all-ones
   // quotient and leaves the dividend as the remainder.
   logic [31:0] q_step, r_step;
   logic [32:0] shifted;

   always_comb begin
      q_step  = quo_reg;
      r_step  = rem_reg;
      shifted = '0;
      for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
         shifted = {r_step, q_step[31]};
         if (shifted >= {1'b0, dvs_reg}) begin
            r_step = shifted[31:0] - dvs_reg;
            q_step = {q_step[30:0], 1'b1};
         end else begin
            r_step = shifted[31:0];
            q_step = {q_step[30:0], 1'b0};
         end
      end
   end

   // Sign fix-up. Divide-by-zero keeps the all-ones quotient unnegated;
   // 0x80000000 / -1 falls out as 0x80000000 with remainder 0.
   logic [31:0] q_fix, r_fix, div_result;
   assign q_fix      = (neg_q_reg && (dvs_reg != 32'd0)) ? -q_step : q_step;
   assign r_fix      = neg_r_reg ? -r_step : r_step;
   assign div_result = is_rem_reg ? r_fix : q_fix;

   // next-state / outputs
   always_comb begin
      state_next      = state_reg;
      ex_mem_next     = '0;
      ex_illegal_next = 1'b0;
      stall           = 1'b0;
      issue           = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.id_valid && !bus.flush) begin
               if (op_is_div) begin
                  // reset_n gate keeps ex_stall low throughout reset
                  issue      = reset_n;
                  stall      = reset_n;
                  state_next = DIV_RUN;
               end else if (op_illegal) begin
                  ex_illegal_next = 1'b1;
               end else begin
                  ex_mem_next.alu_result = alu_res;
                  ex_mem_next.rs2_data   = bus.rs2_data;
                  ex_mem_next.rd         = bus.rd;
                  ex_mem_next.RegWrite   = bus.RegWrite && (bus.rd != 5'd0);
                  ex_mem_next.MemWrite   = bus.MemWrite;
                  ex_mem_next.MemToReg   = bus.MemToReg;
               end
            end
         end
         DIV_RUN: begin
            if (bus.flush) begin
               stall      = 1'b1;
               state_next = IDLE;
            end else if (cnt_reg == 5'd0) begin
               // result cycle: ID may advance at this same edge
               state_next             = IDLE;
               ex_mem_next.alu_result = div_result;
               ex_mem_next.rs2_data   = rs2_hold_reg;
               ex_mem_next.rd         = rd_hold_reg;
               ex_mem_next.RegWrite   = rw_hold_reg;
               ex_mem_next.MemWrite   = mw_hold_reg;
               ex_mem_next.MemToReg   = mtr_hold_reg;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         ex_mem_reg     <= '0;
         ex_illegal_reg <= 1'b0;
         quo_reg        <= '0;
         rem_reg        <= '0;
         dvs_reg        <= '0;
         cnt_reg        <= '0;
         neg_q_reg      <= 1'b0;
         neg_r_reg      <= 1'b0;
         is_rem_reg     <= 1'b0;
         rs2_hold_reg   <= '0;
         rd_hold_reg    <= '0;
         rw_hold_reg    <= 1'b0;
         mw_hold_reg    <= 1'b0;
         mtr_hold_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         ex_mem_reg     <= ex_mem_next;
         ex_illegal_reg <= ex_illegal_next;
         if (issue) begin
            quo_reg      <= (div_signed && op_a[31]) ? -op_a : op_a;
            dvs_reg      <= (div_signed && op_b[31]) ? -op_b : op_b;
            rem_reg      <= '0;
            cnt_reg      <= CNT_INIT;
            neg_q_reg    <= div_signed && (op_a[31] ^ op_b[31]);
            neg_r_reg    <= div_signed && op_a[31];
            is_rem_reg   <= div_is_rem;
            rs2_hold_reg <= bus.rs2_data;
            rd_hold_reg  <= bus.rd;
            rw_hold_reg  <= bus.RegWrite && (bus.rd != 5'd0);
            mw_hold_reg  <= bus.MemWrite;
            mtr_hold_reg <= bus.MemToReg;
         end else if (state_reg == DIV_RUN) begin
            quo_reg <= q_step;
            rem_reg <= r_step;
            cnt_reg <= cnt_reg - 5'd1;
         end
      end
   end

   assign bus.ex_stall   = stall;
   assign bus.ex_illegal = ex_illegal_reg;
   assign bus.ex_mem     = ex_mem_reg;

endmodule

// File: tb/tb_execute.sv
// ----------------------------------------------------------------------------
// tb_execute
//  Directed bench for the EX stage. Each cycle pushes the expected EX/MEM
//  contents and ex_illegal onto a scoreboard, then pops and compares after
//  the edge; ex_stall is checked on the falling edge of the same cycle.
// ----------------------------------------------------------------------------
module tb_execute;
   import execute_pkg::*;

   localparam int      DIVC   = 32;
   localparam ex_mem_t BUBBLE = '0;

   logic clk;
   logic reset_n;

   execute_if bus();

   execute dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   ex_mem_t exp_q[$];
   logic    ill_q[$];
   string   tag_q[$];

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic valid, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic src,
                        input logic [4:0] rd, input logic rw, input logic mw,
                        input logic mtr, input logic fl);
      bus.id_valid = valid;
      bus.alu_op   = op;
      bus.rs1_data = a;
      bus.rs2_data = rs2;
      bus.imm      = imm;
      bus.alu_src  = src;
      bus.rd       = rd;
      bus.RegWrite = rw;
      bus.MemWrite = mw;
      bus.MemToReg = mtr;
      bus.flush    = fl;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic ex_mem_t mk(input logic [31:0] res, input logic [31:0] rs2,
                                  input logic [4:0] rd, input logic rw,
                                  input logic mw, input logic mtr);
      ex_mem_t e;
      e.alu_result = res;
      e.rs2_data   = rs2;
      e.rd         = rd;
      e.RegWrite   = rw;
      e.MemWrite   = mw;
      e.MemToReg   = mtr;
      return e;
   endfunction

   // one clock: stall checked mid-cycle, EX/MEM and ex_illegal after the edge
   task automatic cyc(input ex_mem_t exp, input logic exp_ill, input logic exp_stall,
                      input string tag);
      ex_mem_t e;
      logic    il;
      string   t;
      exp_q.push_back(exp);
      ill_q.push_back(exp_ill);
      tag_q.push_back(tag);
      @(negedge clk);
      check({tag, ":stall"}, 72'(bus.ex_stall), 72'(exp_stall));
      @(posedge clk);
      #1;
      e  = exp_q.pop_front();
      il = ill_q.pop_front();
      t  = tag_q.pop_front();
      check({t, ":ex_mem"}, bus.ex_mem, e);
      check({t, ":illegal"}, 72'(bus.ex_illegal), 72'(il));
   endtask

   // reference divide with the RISC-V corner cases
   function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
         OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:  return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic do_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input string tag);
      drive(1'b1, op, a, b, 32'h0000_0BAD, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(BUBBLE, 1'b0, 1'b1, {tag, "/issue"});
      for (int i = 0; i < DIVC - 1; i++)
         cyc(BUBBLE, 1'b0, 1'b1, {tag, "/run"});
      cyc(mk(res, b, 5'd5, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, {tag, "/result"});
      idle();
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [4:0]  rop;

      reset_n = 1'b0;
      idle();
      #12;
      check("reset:ex_mem", bus.ex_mem, BUBBLE);
      check("reset:stall", 72'(bus.ex_stall), 72'(1'b0));
      check("reset:illegal", 72'(bus.ex_illegal), 72'(1'b0));
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // single-cycle ops
      drive(1, OP_ADD, 32'd5, 32'h55, 32'hFFFF_FFFD, 1, 5'd7, 1, 0, 0, 0);
      cyc(mk(32'd2, 32'h55, 5'd7, 1, 0, 0), 0, 0, "add_imm");
      drive(1, OP_SUB, 32'd10, 32'd3, 32'd99, 0, 5'd1, 1, 0, 0, 0);
      cyc(mk(32'd7, 32'd3, 5'd1, 1, 0, 0), 0, 0, "sub");
      drive(1, OP_AND, 32'hF0F0, 32'hFF00, 32'd0, 0, 5'd2, 1, 0, 0, 0);
      cyc(mk(32'hF000, 32'hFF00, 5'd2, 1, 0, 0), 0, 0, "and");
      drive(1, OP_OR, 32'hF0F0, 32'hFF00, 32'd0, 0, 5'd3, 1, 0, 0, 0);
      cyc(mk(32'hFFF0, 32'hFF00, 5'd3, 1, 0, 0), 0, 0, "or");
      drive(1, OP_XOR, 32'hF0F0, 32'hFF00, 32'd0, 0, 5'd4, 1, 0, 0, 0);
      cyc(mk(32'h0FF0, 32'hFF00, 5'd4, 1, 0, 0), 0, 0, "xor");
      drive(1, OP_SLL, 32'd1, 32'd0, 32'h23, 1, 5'd6, 1, 0, 0, 0);
      cyc(mk(32'd8, 32'd0, 5'd6, 1, 0, 0), 0, 0, "sll_b40");
      drive(1, OP_SRL, 32'h8000_0000, 32'd4, 32'd0, 0, 5'd8, 1, 0, 0, 0);
      cyc(mk(32'h0800_0000, 32'd4, 5'd8, 1, 0, 0), 0, 0, "srl");
      drive(1, OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 0, 5'd9, 1, 0, 0, 0);
      cyc(mk(32'hF800_0000, 32'd4, 5'd9, 1, 0, 0), 0, 0, "sra");
      drive(1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 5'd10, 1, 0, 0, 0);
      cyc(mk(32'd1, 32'd1, 5'd10, 1, 0, 0), 0, 0, "slt");
      drive(1, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 5'd11, 1, 0, 0, 0);
      cyc(mk(32'd0, 32'd1, 5'd11, 1, 0, 0), 0, 0, "sltu");
      drive(1, OP_PASSB, 32'd7, 32'hAA, 32'h1234_5000, 1, 5'd12, 1, 0, 1, 0);
      cyc(mk(32'h1234_5000, 32'hAA, 5'd12, 1, 0, 1), 0, 0, "passb");
      // store with rd=0: RegWrite dropped, store data is rs2 not imm
      drive(1, OP_ADD, 32'h1000, 32'hDEAD_BEEF, 32'd8, 1, 5'd0, 1, 1, 0, 0);
      cyc(mk(32'h1008, 32'hDEAD_BEEF, 5'd0, 0, 1, 0), 0, 0, "sw_rd0");

      // bubbles
      drive(0, OP_ADD, 32'd1, 32'd1, 32'd0, 0, 5'd3, 1, 0, 0, 0);
      cyc(BUBBLE, 0, 0, "no_valid");
      drive(1, OP_ADD, 32'd1, 32'd1, 32'd0, 0, 5'd3, 1, 0, 0, 1);
      cyc(BUBBLE, 0, 0, "flush");
      drive(1, 5'd20, 32'd1, 32'd1, 32'd0, 0, 5'd3, 1, 0, 0, 0);
      cyc(BUBBLE, 1, 0, "illegal20");
      idle();
      cyc(BUBBLE, 0, 0, "illegal_pulse_end");
      drive(1, 5'd31, 32'd1, 32'd1, 32'd0, 0, 5'd3, 1, 0, 0, 1);
      cyc(BUBBLE, 0, 0, "illegal_flushed");

      drive(1, OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 5'd4, 1, 0, 0, 0);
`ifdef EXECUTE_MUL_EN
      cyc(mk(32'd0, 32'hFFFF_FFFF, 5'd4, 1, 0, 0), 0, 0, "mulh");
`else
      cyc(BUBBLE, 1, 0, "mulh_disabled");
`endif
      idle();

      // divides
      do_div(OP_DIVU, 32'd100, 32'd7, 32'd14, "divu_100_7");
      do_div(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
      do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
      do_div(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by0");
      do_div(OP_REMU, 32'd5, 32'd0, 32'd5, "remu_by0");
      do_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
      do_div(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
      for (int k = 0; k < 4; k++) begin
         ra  = $urandom;
         rb  = (k == 1) ? $urandom : 32'($urandom_range(1, 5000));
         rop = 5'(OP_DIV + k);
         do_div(rop, ra, rb, ref_div(rop, ra, rb), "rnd_div");
      end

      // flush in the 10th DIV_RUN cycle
      drive(1, OP_DIV, 32'd1000, 32'd3, 32'd0, 0, 5'd5, 1, 0, 0, 0);
      cyc(BUBBLE, 0, 1, "flushdiv/issue");
      for (int i = 0; i < 9; i++)
         cyc(BUBBLE, 0, 1, "flushdiv/run");
      bus.flush = 1'b1;
      cyc(BUBBLE, 0, 1, "flushdiv/flush");
      drive(1, OP_ADD, 32'd40, 32'd2, 32'd0, 0, 5'd9, 1, 0, 0, 0);
      cyc(mk(32'd42, 32'd2, 5'd9, 1, 0, 0), 0, 0, "flushdiv/add_after");

      // flush coincident with issue: no divide starts
      drive(1, OP_DIVU, 32'd9, 32'd3, 32'd0, 0, 5'd5, 1, 0, 0, 1);
      cyc(BUBBLE, 0, 0, "flush_issue");
      drive(1, OP_ADD, 32'd1, 32'd2, 32'd0, 0, 5'd6, 1, 0, 0, 0);
      cyc(mk(32'd3, 32'd2, 5'd6, 1, 0, 0), 0, 0, "flush_issue/add");

      // asynchronous reset mid-divide
      drive(1, OP_DIVU, 32'd77, 32'd7, 32'd0, 0, 5'd5, 1, 0, 0, 0);
      cyc(BUBBLE, 0, 1, "rstdiv/issue");
      for (int i = 0; i < 5; i++)
         cyc(BUBBLE, 0, 1, "rstdiv/run");
      #2;
      reset_n = 1'b0;
      #1;
      check("rstdiv:ex_mem", bus.ex_mem, BUBBLE);
      check("rstdiv:stall", 72'(bus.ex_stall), 72'(1'b0));
      reset_n = 1'b1;
      idle();
      cyc(BUBBLE, 0, 0, "rstdiv/idle");
      drive(1, OP_ADD, 32'd20, 32'd22, 32'd0, 0, 5'd7, 1, 0, 0, 0);
      cyc(mk(32'd42, 32'd22, 5'd7, 1, 0, 0), 0, 0, "rstdiv/add");
      idle();
      cyc(BUBBLE, 0, 0, "final_idle");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
